key_scan_arbiter: RTL and testbench

KEY_SCAN_ARBITER -- requirements
Module: key_scan_arbiter

---
 rtl/key_pkg.sv | 6 +
 rtl/key_sync.sv | 19 +
 rtl/key_scan_arbiter.sv | 83 ++++++++
 tb/tb_key_scan_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type and default sizing for the key scan arbiter.
package key_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_COMMIT} state_t;
  localparam int N_KEY_DEF = 4;
  localparam int DEBOUNCE_CYC_DEF = 1_000_000;
endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchronizer for one idle-high key input.
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/key_scan_arbiter.sv
// key_scan_arbiter: debounces N_KEY keys with one shared settle counter granted round-robin.
module key_scan_arbiter
  import key_pkg::*;
#(
  parameter int N_KEY = N_KEY_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  localparam int GW = (N_KEY > 1) ? $clog2(N_KEY) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_KEY-1:0] i_key,
  output logic [N_KEY-1:0] key_state,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic             busy,
  output logic [GW-1:0]    grant_id
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  logic [N_KEY-1:0] w_key_s, w_pending;
  logic [N_KEY-1:0] r_key_state, r_press, r_rel;
  logic [GW-1:0]    r_grant, w_next;
  logic [CW-1:0]    r_cnt;
  logic             w_gs, w_gk;
  state_t           r_state;

  for (genvar g = 0; g < N_KEY; g++) begin : g_sync
    key_sync u_sync (.clk(clk), .rst(rst), .i_d(i_key[g]), .o_q(w_key_s[g]));
  end

  assign w_pending = w_key_s ^ r_key_state;
  assign w_gs = w_key_s[r_grant];
  assign w_gk = r_key_state[r_grant];

  // Scan from farthest to nearest so the key right after the last grant wins.
  always_comb begin
    w_next = r_grant;
    for (int k = N_KEY; k >= 1; k--) begin
      int j;
      j = (int'(r_grant) + k) % N_KEY;
      if (w_pending[j]) w_next = GW'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_grant     <= GW'(N_KEY - 1);
      r_key_state <= '1;
      r_press     <= '0;
      r_rel       <= '0;
    end else begin
      r_press <= '0;
      r_rel   <= '0;
      case (r_state)
        S_IDLE: if (|w_pending) begin
          r_grant <= w_next;
          r_cnt   <= '0;
          r_state <= S_COUNT;
        end
        S_COUNT: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (w_gs == w_gk) ? S_IDLE : (r_cnt == CW'(DEBOUNCE_CYC - 1)) ? S_COMMIT : S_COUNT;
        end
        S_COMMIT: begin
          if (w_gs != w_gk) begin
            r_key_state[r_grant] <= w_gs;
            r_press[r_grant]     <= ~w_gs;
            r_rel[r_grant]       <= w_gs;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_state   = r_key_state;
  assign key_press   = r_press;
  assign key_release = r_rel;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;
endmodule

// File: tb/tb_key_scan_arbiter.sv
// tb_key_scan_arbiter: directed stimulus with a queue scoreboard checked by a pulse monitor.
module tb_key_scan_arbiter;
  localparam int N = 4;
  localparam int D = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] i_key = '1;
  logic [N-1:0] key_state, key_press, key_release;
  logic busy;
  logic [1:0] grant_id;
  int cyc = 0, checks = 0, passed = 0;

  typedef struct {
    int at;
    logic [3:0] pr, rl, st;
    logic [1:0] gid;
  } exp_t;
  exp_t q[$];

  key_scan_arbiter #(.N_KEY(N), .DEBOUNCE_CYC(D)) dut (
    .clk(clk), .rst(rst), .i_key(i_key), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
  endtask

  task automatic push(input int at, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] st, input logic [1:0] gid);
    exp_t e;
    e.at = at; e.pr = pr; e.rl = rl; e.st = st; e.gid = gid;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset();
    chk("rst_key_state", key_state, 4'b1111);
    chk("rst_press", key_press, 4'b0000);
    chk("rst_release", key_release, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 2'd3);
  endtask

  always @(negedge clk) begin
    if (|(key_press | key_release)) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: press %b release %b at edge %0d", key_press, key_release, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_edge", cyc, e.at);
        chk("pulse_press", key_press, e.pr);
        chk("pulse_release", key_release, e.rl);
        chk("pulse_key_state", key_state, e.st);
        chk("pulse_grant_id", grant_id, e.gid);
      end
    end
  end

  initial begin
    int k;
    step(3);
    chk_reset();
    rst = 0;
    step(1);
    // clean press on key 1, then its release
    i_key = 4'b1101; k = cyc + 1;
    push(k + D + 3, 4'b0010, 4'b0000, 4'b1101, 2'd1);
    step(25);
    chk("press_key_state", key_state, 4'b1101);
    i_key = 4'b1111; k = cyc + 1;
    push(k + D + 3, 4'b0000, 4'b0010, 4'b1111, 2'd1);
    step(25);
    // bounce on key 0: counter granted then abandoned
    i_key = 4'b1110;
    step(10);
    chk("bounce_busy_high", busy, 1'b1);
    chk("bounce_grant_id", grant_id, 2'd0);
    i_key = 4'b1111;
    step(6);
    chk("bounce_busy_low", busy, 1'b0);
    chk("bounce_key_state", key_state, 4'b1111);
    // simultaneous keys 0 and 2 right after reset, then simultaneous release
    rst = 1;
    step(2);
    rst = 0;
    i_key = 4'b1010; k = cyc + 1;
    push(k + D + 3, 4'b0001, 4'b0000, 4'b1110, 2'd0);
    push(k + 2 * D + 5, 4'b0100, 4'b0000, 4'b1010, 2'd2);
    step(42);
    chk("sim_grant_id", grant_id, 2'd2);
    chk("sim_key_state", key_state, 4'b1010);
    i_key = 4'b1111; k = cyc + 1;
    push(k + D + 3, 4'b0000, 4'b0001, 4'b1011, 2'd0);
    push(k + 2 * D + 5, 4'b0000, 4'b0100, 4'b1111, 2'd2);
    step(42);
    // reset while key 3 is mid-count at counter value 8
    i_key = 4'b0111; k = cyc + 1;
    step(11);
    chk("midcount_busy", busy, 1'b1);
    rst = 1;
    step(2);
    chk_reset();
    rst = 0; k = cyc + 1;
    push(k + D + 3, 4'b1000, 4'b0000, 4'b0111, 2'd3);
    step(24);
    i_key = 4'b1111; k = cyc + 1;
    push(k + D + 3, 4'b0000, 4'b1000, 4'b1111, 2'd3);
    step(24);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL missing_pulses: %0d expected pulses never seen", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
